// File: rtl/ex_stage_unit.sv
// Execute stage: ALU with a multi-cycle multiply feeding a single-entry EX/MEM slot.
// Define EX_FWD_EN to add the combinational forwarding outputs (fwd_valid/fwd_reg/fwd_data).
module ex_stage_unit #(
    parameter int DW      = 32,
    parameter int RW      = 4,
    parameter int MUL_LAT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] r1_i,
    input  logic [DW-1:0] r2_i,
    input  logic [DW-1:0] r3_i,
    input  logic [RW-1:0] dest_i,
    input  logic [2:0]    alu_op_i,
    input  logic          wmem_i,
    input  logic          rmem_i,
    input  logic          wreg_i,
    input  logic          imm_i,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] result_o,
    output logic [DW-1:0] store_o,
    output logic [RW-1:0] dest_o,
    output logic          wmem_o,
    output logic          rmem_o,
    output logic          wreg_o,
    output logic          busy_o
`ifdef EX_FWD_EN
    ,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_reg,
    output logic [DW-1:0] fwd_data
`endif
);

    localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic {IDLE, MUL} state_t;

    // Handshake: a bundle transfers on in_valid && in_ready, the slot drains on
    // out_valid && out_ready; flush overrides both except rst.
    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] mul_a, mul_b, mul_store;
    logic [RW-1:0] mul_dest;
    logic          mul_wmem, mul_rmem, mul_wreg;

    logic [DW-1:0] opb, alu_res, mul_res;
    logic          slot_free, accept;

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && slot_free;
    assign accept    = in_valid && in_ready;
    assign opb       = imm_i ? {{(DW-16){1'b0}}, r3_i[15:0]} : r3_i;
    assign mul_res   = mul_a * mul_b;

    always_comb begin
        alu_res = '0;
        case (alu_op_i)
            3'b000:  alu_res = r2_i + opb;
            3'b001:  alu_res = r2_i - opb;
            3'b010:  alu_res = r2_i & opb;
            3'b011:  alu_res = r2_i | opb;
            3'b100:  alu_res = r2_i ^ opb;
            3'b101:  alu_res = r2_i << opb[4:0];
            3'b110:  alu_res = r2_i >> opb[4:0];
            default: alu_res = r2_i * opb;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            busy_o    <= 1'b0;
            out_valid <= 1'b0;
            result_o  <= '0;
            store_o   <= '0;
            dest_o    <= '0;
            wmem_o    <= 1'b0;
            rmem_o    <= 1'b0;
            wreg_o    <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_store <= '0;
            mul_dest  <= '0;
            mul_wmem  <= 1'b0;
            mul_rmem  <= 1'b0;
            mul_wreg  <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            busy_o    <= 1'b0;
            out_valid <= 1'b0;
            wmem_o    <= 1'b0;
            rmem_o    <= 1'b0;
            wreg_o    <= 1'b0;
        end else begin
            // A drain with no load this edge empties the slot; loads below override.
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && alu_op_i == OP_MUL) begin
                        mul_a     <= r2_i;
                        mul_b     <= opb;
                        mul_store <= r1_i;
                        mul_dest  <= dest_i;
                        mul_wmem  <= wmem_i;
                        mul_rmem  <= rmem_i;
                        mul_wreg  <= wreg_i;
                        cnt       <= CW'(MUL_LAT - 1);
                        busy_o    <= 1'b1;
                        state     <= MUL;
                    end else if (accept) begin
                        result_o  <= alu_res;
                        store_o   <= r1_i;
                        dest_o    <= dest_i;
                        wmem_o    <= wmem_i;
                        rmem_o    <= rmem_i;
                        wreg_o    <= wreg_i;
                        out_valid <= 1'b1;
                    end
                end
                MUL: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (slot_free) begin
                        result_o  <= mul_res;
                        store_o   <= mul_store;
                        dest_o    <= mul_dest;
                        wmem_o    <= mul_wmem;
                        rmem_o    <= mul_rmem;
                        wreg_o    <= mul_wreg;
                        out_valid <= 1'b1;
                        busy_o    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EX_FWD_EN
    // Loads are excluded: their value only exists after the memory stage.
    assign fwd_valid = out_valid && wreg_o && !rmem_o;
    assign fwd_reg   = dest_o;
    assign fwd_data  = result_o;
`endif

endmodule

// File: tb/tb_ex_stage_unit.sv
// Directed bench for ex_stage_unit: ALU ops, immediate, multiply latency, backpressure, flush, reset.
module tb_ex_stage_unit;

    localparam int DW      = 32;
    localparam int RW      = 4;
    localparam int MUL_LAT = 4;

    logic          clk, rst;
    logic          in_valid, in_ready;
    logic [DW-1:0] r1_i, r2_i, r3_i;
    logic [RW-1:0] dest_i;
    logic [2:0]    alu_op_i;
    logic          wmem_i, rmem_i, wreg_i, imm_i, flush;
    logic          out_valid, out_ready;
    logic [DW-1:0] result_o, store_o;
    logic [RW-1:0] dest_o;
    logic          wmem_o, rmem_o, wreg_o, busy_o;
`ifdef EX_FWD_EN
    logic          fwd_valid;
    logic [RW-1:0] fwd_reg;
    logic [DW-1:0] fwd_data;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ex_stage_unit #(.DW(DW), .RW(RW), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .r1_i(r1_i), .r2_i(r2_i), .r3_i(r3_i), .dest_i(dest_i), .alu_op_i(alu_op_i),
        .wmem_i(wmem_i), .rmem_i(rmem_i), .wreg_i(wreg_i), .imm_i(imm_i), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .result_o(result_o), .store_o(store_o),
        .dest_o(dest_o), .wmem_o(wmem_o), .rmem_o(rmem_o), .wreg_o(wreg_o), .busy_o(busy_o)
`ifdef EX_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1);
    end

    // Driver tasks: inputs change on the falling edge, outputs are checked there too.
    task automatic set_bundle(input logic [2:0] op, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                              input logic [DW-1:0] r3, input logic [RW-1:0] dest, input logic imm,
                              input logic wmem, input logic rmem, input logic wreg);
        alu_op_i = op; r1_i = r1; r2_i = r2; r3_i = r3; dest_i = dest;
        imm_i = imm; wmem_i = wmem; rmem_i = rmem; wreg_i = wreg;
        in_valid = 1'b1;
    endtask

    // Present one bundle for one edge (caller ensures in_ready), end on the next falling edge.
    task automatic issue(input logic [2:0] op, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                         input logic [DW-1:0] r3, input logic [RW-1:0] dest, input logic imm,
                         input logic wmem, input logic rmem, input logic wreg);
        set_bundle(op, r1, r2, r3, dest, imm, wmem, rmem, wreg);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        r1_i = '0; r2_i = '0; r3_i = '0; dest_i = '0; alu_op_i = '0;
        wmem_i = 1'b0; rmem_i = 1'b0; wreg_i = 1'b0; imm_i = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        n_cmp++; if (result_o !== 32'h0) begin n_err++; $display("FAIL reset_result got=%0h exp=0", result_o); end
        n_cmp++; if ({wmem_o, rmem_o, wreg_o, dest_o} !== 7'h0) begin n_err++; $display("FAIL reset_ctrl got=%0h exp=0", {wmem_o, rmem_o, wreg_o, dest_o}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add;
        issue(3'b000, 32'hAA, 32'd5, 32'd7, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_valid got=%0b exp=1", out_valid); end
        n_cmp++; if (result_o !== 32'd12) begin n_err++; $display("FAIL add_result got=%0h exp=c", result_o); end
        n_cmp++; if (dest_o !== 4'd3) begin n_err++; $display("FAIL add_dest got=%0h exp=3", dest_o); end
        n_cmp++; if (wreg_o !== 1'b1) begin n_err++; $display("FAIL add_wreg got=%0b exp=1", wreg_o); end
        n_cmp++; if (store_o !== 32'hAA) begin n_err++; $display("FAIL add_store got=%0h exp=aa", store_o); end
    endtask

    // Back-to-back ALU ops on A=F0F01234, B=0FF000FF with out_ready held high.
    task automatic test_back_to_back;
        logic [DW-1:0] exp_tab [5];
        exp_tab[0] = 32'h00E0_1333;
        exp_tab[1] = 32'hE100_1135;
        exp_tab[2] = 32'h00F0_0034;
        exp_tab[3] = 32'hFFF0_12FF;
        exp_tab[4] = 32'hFF00_12CB;
        for (int i = 0; i < 5; i++) begin
            issue(3'(i), 32'h0, 32'hF0F0_1234, 32'h0FF0_00FF, 4'(i), 1'b0, 1'b1, 1'b0, 1'b0);
            n_cmp++; if (out_valid !== 1'b1 || result_o !== exp_tab[i]) begin n_err++; $display("FAIL alu_op%0d got=%0h exp=%0h", i, result_o, exp_tab[i]); end
            n_cmp++; if (wmem_o !== 1'b1 || dest_o !== 4'(i)) begin n_err++; $display("FAIL alu_ctrl%0d got=%0h exp=%0h", i, {wmem_o, dest_o}, {1'b1, 4'(i)}); end
        end
        drain();
    endtask

    task automatic test_imm_shift;
        issue(3'b101, 32'h0, 32'h1, 32'hFFFF_0004, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (result_o !== 32'h10) begin n_err++; $display("FAIL shl_imm got=%0h exp=10", result_o); end
        issue(3'b101, 32'h0, 32'h1, 32'hFFFF_0004, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (result_o !== 32'h10) begin n_err++; $display("FAIL shl_reg got=%0h exp=10", result_o); end
        issue(3'b110, 32'h0, 32'h8000_0000, 32'd31, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (result_o !== 32'h1) begin n_err++; $display("FAIL shr got=%0h exp=1", result_o); end
        issue(3'b000, 32'h0, 32'h1, 32'hFFFF_0004, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (result_o !== 32'h5) begin n_err++; $display("FAIL add_imm got=%0h exp=5", result_o); end
        issue(3'b000, 32'h0, 32'h1, 32'hFFFF_0004, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (result_o !== 32'hFFFF_0005) begin n_err++; $display("FAIL add_reg got=%0h exp=ffff0005", result_o); end
        drain();
    endtask

    task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] exp_p);
        int cyc;
        cyc = 0;
        issue(3'b111, 32'h0, a, b, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1);
        while (out_valid !== 1'b1 && cyc < 20) begin
            n_cmp++; if (busy_o !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL mul_busy cyc=%0d got=%0b%0b exp=10", cyc, busy_o, in_ready); end
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (cyc !== MUL_LAT) begin n_err++; $display("FAIL mul_latency got=%0d exp=%0d", cyc, MUL_LAT); end
        n_cmp++; if (result_o !== exp_p || dest_o !== 4'd7) begin n_err++; $display("FAIL mul_result got=%0h exp=%0h", result_o, exp_p); end
        n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL mul_busy_clear got=%0b exp=0", busy_o); end
    endtask

    task automatic test_mul;
        run_mul(32'd6, 32'd7, 32'd42);
        run_mul(32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
        drain();
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        issue(3'b000, 32'h0, 32'd1, 32'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        set_bundle(3'b000, 32'h0, 32'd3, 32'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || result_o !== 32'd2 || dest_o !== 4'd2) begin n_err++; $display("FAIL bp_hold%0d got=%0h exp=2", i, result_o); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready%0d got=%0b exp=0", i, in_ready); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || result_o !== 32'd7 || dest_o !== 4'd4) begin n_err++; $display("FAIL bp_no_bubble got=%0h exp=7", result_o); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush;
        int seen;
        seen = 0;
        issue(3'b111, 32'h0, 32'd9, 32'd9, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_cmp++; if (busy_o !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL flush_mul got=%0b%0b exp=00", busy_o, out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1 || result_o === 32'd81) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL flush_no_81 got=%0d exp=0", seen); end
        // A bundle offered in the flush cycle must be dropped.
        set_bundle(3'b000, 32'h0, 32'd2, 32'd3, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || wreg_o !== 1'b0) begin n_err++; $display("FAIL flush_discard got=%0b%0b exp=00", out_valid, wreg_o); end
        // A stalled slot is killed and its flags cleared.
        out_ready = 1'b0;
        issue(3'b000, 32'h0, 32'd2, 32'd3, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_ready = 1'b1;
        n_cmp++; if ({out_valid, wmem_o, rmem_o, wreg_o} !== 4'b0000) begin n_err++; $display("FAIL flush_slot got=%0b exp=0000", {out_valid, wmem_o, rmem_o, wreg_o}); end
    endtask

    task automatic test_reset_mid_mul;
        int seen;
        seen = 0;
        issue(3'b111, 32'h0, 32'd5, 32'd5, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy_o !== 1'b0 || out_valid !== 1'b0 || wreg_o !== 1'b0) begin n_err++; $display("FAIL rst_async got=%0b%0b%0b exp=000", busy_o, out_valid, wreg_o); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_no_result got=%0d exp=0", seen); end
    endtask

`ifdef EX_FWD_EN
    task automatic test_fwd;
        issue(3'b000, 32'h0, 32'd2, 32'd2, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (fwd_valid !== 1'b1 || fwd_reg !== 4'd5 || fwd_data !== 32'd4) begin n_err++; $display("FAIL fwd_alu got=%0b/%0h/%0h exp=1/5/4", fwd_valid, fwd_reg, fwd_data); end
        issue(3'b000, 32'h0, 32'h100, 32'd4, 4'd6, 1'b0, 1'b0, 1'b1, 1'b1);
        n_cmp++; if (fwd_valid !== 1'b0 || result_o !== 32'h104) begin n_err++; $display("FAIL fwd_load got=%0b/%0h exp=0/104", fwd_valid, result_o); end
        drain();
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_imm_shift();
        test_mul();
        test_backpressure();
        test_flush();
        test_reset_mid_mul();
`ifdef EX_FWD_EN
        test_fwd();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
